// File: rtl/ysyx_25020042_encoder.sv
// I-type ALU-immediate encoder feeding a small circular output FIFO.
// Illegal requests (unknown op code or out-of-range immediate) are dropped and flagged on err.
module ysyx_25020042_encoder #(
  parameter int INS_BYTES    = 4,
  parameter int REG_ADDR_LEN = 5,
  parameter int DEPTH        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  instruction,
  input  logic [REG_ADDR_LEN-1:0]     rd,
  input  logic [REG_ADDR_LEN-1:0]     rs1,
  input  logic [INS_BYTES*8-1:0]      imm,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INS_BYTES*8-1:0]      ins,
  output logic                        err,
  output logic [$clog2(DEPTH):0]      count,
  output logic [31:0]                 emitted
);
  localparam int W     = INS_BYTES * 8;
  localparam int PW    = $clog2(DEPTH);
  localparam int ENC_W = 22 + 2 * REG_ADDR_LEN;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW:0]   r_count;
  logic [31:0]   r_emitted;
  logic          r_err;

  logic [2:0]       w_funct3;
  logic             w_code_ok, w_imm_ok, w_accept, w_push, w_pop;
  logic [ENC_W-1:0] w_enc;
  logic [W-1:0]     w_word;

  always_comb begin
    w_funct3  = 3'b000;
    w_code_ok = 1'b1;
    case (instruction)
      8'h01:   w_funct3 = 3'b000;
      8'h02:   w_funct3 = 3'b010;
      8'h03:   w_funct3 = 3'b011;
      8'h04:   w_funct3 = 3'b100;
      8'h05:   w_funct3 = 3'b110;
      8'h06:   w_funct3 = 3'b111;
      default: w_code_ok = 1'b0;
    endcase
  end

  // Immediate fits in 12-bit signed when everything from bit 11 up is a sign copy.
  assign w_imm_ok = (&imm[W-1:11]) | ~(|imm[W-1:11]);
  assign w_enc    = {imm[11:0], rs1, w_funct3, rd, 7'b0010011};

  generate
    if (W > ENC_W) begin : g_pad
      assign w_word = {{(W-ENC_W){1'b0}}, w_enc};
    end else begin : g_fit
      assign w_word = w_enc[W-1:0];
    end
  endgenerate

  assign in_ready  = (r_count != (PW+1)'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid & in_ready;
  assign w_push    = w_accept & w_code_ok & w_imm_ok;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_emitted <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept & ~(w_code_ok & w_imm_ok);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_emitted <= r_emitted + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= w_word;
  end

  assign ins     = r_mem[r_rd_ptr];
  assign err     = r_err;
  assign count   = r_count;
  assign emitted = r_emitted;
endmodule
